// File: rtl/seq_divider_if.sv
// Handshake and result bundle between the control unit (master) and the
// iterative divider (slave). SGN exists only when SIGNED_DIV_EN is defined.
interface seq_divider_if #(
    parameter int WIDTH = 8
);
    logic             START;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
`ifdef SIGNED_DIV_EN
    logic             SGN;
`endif
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] R;
    logic             DZ;
    logic             V;

`ifdef SIGNED_DIV_EN
    modport master (output START, A, B, SGN, input BUSY, DONE, Q, R, DZ, V);
    modport slave  (input START, A, B, SGN, output BUSY, DONE, Q, R, DZ, V);
`else
    modport master (output START, A, B, input BUSY, DONE, Q, R, DZ, V);
    modport slave  (input START, A, B, output BUSY, DONE, Q, R, DZ, V);
`endif
endinterface

// File: rtl/seq_divider.sv
// Iterative restoring divider: one quotient bit per clock, START/DONE handshake.
// Optional signed mode (SGN port, V flag, one fix-up cycle) under `SIGNED_DIV_EN.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic          CLK,
    input  logic          RST,
    seq_divider_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] dvd;      // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] div;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] q_reg, r_reg;
    logic             dz_reg;

    logic [WIDTH:0]   rem_sh, trial;
    logic [WIDTH-1:0] q_fin, r_fin, a_op, b_op;
    logic             q_bit, start_ok, div_zero, step_last, load_now;

`ifdef SIGNED_DIV_EN
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic             sgn_op, neg_q, neg_r, ovf, v_reg, fix_step;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
        return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction
`endif

    // NOTE: every signal assigned in an always_comb gets a default first so
    // no path through the block can leave it unassigned and infer a latch.
    always_comb begin
        rem_sh    = {rem, dvd[WIDTH-1]};
        trial     = rem_sh - {1'b0, div};
        q_bit     = ~trial[WIDTH];
        q_fin     = {dvd[WIDTH-2:0], q_bit};
        r_fin     = q_bit ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        start_ok  = (state == IDLE) && bus.START;
        div_zero  = (bus.B == '0);
        step_last = (state == RUN) && (count == LAST_STEP);
`ifdef SIGNED_DIV_EN
        // Divide magnitudes; the signs are reapplied in the extra RUN cycle.
        a_op      = (bus.SGN && bus.A[WIDTH-1]) ? negate(bus.A) : bus.A;
        b_op      = (bus.SGN && bus.B[WIDTH-1]) ? negate(bus.B) : bus.B;
        fix_step  = (state == RUN) && (count == CW'(WIDTH));
        load_now  = (step_last && !sgn_op) || fix_step;
`else
        a_op      = bus.A;
        b_op      = bus.B;
        load_now  = step_last;
`endif
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.START) state_nxt = div_zero ? FIN : RUN;
            RUN:     if (load_now)  state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: the reset clears the full datapath (a handful of flops, no memory
    // arrays), so an aborted operation leaves nothing stale behind.
    always_ff @(posedge CLK) begin
        if (RST) begin
            count  <= '0;
            dvd    <= '0;
            div    <= '0;
            rem    <= '0;
            q_reg  <= '0;
            r_reg  <= '0;
            dz_reg <= 1'b0;
`ifdef SIGNED_DIV_EN
            sgn_op <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            ovf    <= 1'b0;
            v_reg  <= 1'b0;
`endif
        end else if (start_ok) begin
            count <= '0;
            dvd   <= a_op;
            div   <= b_op;
            rem   <= '0;
`ifdef SIGNED_DIV_EN
            sgn_op <= bus.SGN;
            neg_q  <= bus.SGN && (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
            neg_r  <= bus.SGN && bus.A[WIDTH-1];
            ovf    <= bus.SGN && (bus.A == MOST_NEG) && (bus.B == '1);
`endif
            if (div_zero) begin
                q_reg  <= '1;
                r_reg  <= bus.A;
                dz_reg <= 1'b1;
`ifdef SIGNED_DIV_EN
                v_reg  <= 1'b0;
`endif
            end
        end else if (state == RUN) begin
            count <= count + CW'(1);
`ifdef SIGNED_DIV_EN
            if (fix_step) begin
                q_reg  <= neg_q ? negate(dvd) : dvd;
                r_reg  <= neg_r ? negate(rem) : rem;
                dz_reg <= 1'b0;
                v_reg  <= ovf;
            end else begin
                dvd <= q_fin;
                rem <= r_fin;
                if (step_last && !sgn_op) begin
                    q_reg  <= q_fin;
                    r_reg  <= r_fin;
                    dz_reg <= 1'b0;
                    v_reg  <= 1'b0;
                end
            end
`else
            dvd <= q_fin;
            rem <= r_fin;
            if (step_last) begin
                q_reg  <= q_fin;
                r_reg  <= r_fin;
                dz_reg <= 1'b0;
            end
`endif
        end
    end

    assign bus.BUSY = (state != IDLE);
    assign bus.DONE = (state == FIN);
    assign bus.Q    = q_reg;
    assign bus.R    = r_reg;
    assign bus.DZ   = dz_reg;
`ifdef SIGNED_DIV_EN
    assign bus.V    = v_reg;
`else
    assign bus.V    = 1'b0;
`endif
endmodule
